// File: rtl/pc_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_sequencer: IF-stage fetch controller (PC update, imem fetch,  |
// | redirect/stall/halt arbitration).           Rev 1.0 initial      |
// +------------------------------------------------------------------+
module pc_sequencer #(
  parameter int              ADDR_W   = 13,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              STEP     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              imem_ack,
  output logic              imem_req,
  output logic              pc_write,
  output logic [ADDR_W-1:0] pc_next,
  output logic              if_valid,
  output logic              flush,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] c_step = ADDR_W'(STEP);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_REQ        = 2'd1,
    S_WAIT_STALL = 2'd2,
    S_HALT       = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_pend_vld;
  logic [ADDR_W-1:0] r_pend_tgt;
  logic              r_halt_pend;
  logic              w_pend_vld_next;
  logic [ADDR_W-1:0] w_pend_tgt_next;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_tgt;
  logic              w_halt;

  assign w_redirect = jump | branch_taken;
  assign w_tgt      = jump ? jump_target : branch_target;
  assign w_halt     = halt_req | r_halt_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pend_vld  <= 1'b0;
      r_pend_tgt  <= '0;
      r_halt_pend <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pend_vld  <= w_pend_vld_next;
      r_pend_tgt  <= w_pend_tgt_next;
      // Halt stays pending until the FSM actually enters HALT
      r_halt_pend <= w_halt && (w_state_next != S_HALT);
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pend_vld_next = r_pend_vld;
    w_pend_tgt_next = r_pend_tgt;
    imem_req        = 1'b0;
    pc_write        = 1'b0;
    pc_next         = pc_cur;
    if_valid        = 1'b0;
    flush           = 1'b0;
    busy            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_redirect) begin
          pc_write = 1'b1;
          pc_next  = w_tgt;
          flush    = 1'b1;
        end
        if (w_halt)      w_state_next = S_HALT;
        else if (start)  w_state_next = S_REQ;
      end

      S_REQ: begin
        imem_req = 1'b1;
        busy     = 1'b1;
        if (imem_ack) begin
          if (w_redirect || r_pend_vld) begin
            pc_write        = 1'b1;
            pc_next         = w_redirect ? w_tgt : r_pend_tgt;
            flush           = w_redirect;
            w_pend_vld_next = 1'b0;
          end else if (!stall) begin
            if_valid = 1'b1;
            pc_write = 1'b1;
            pc_next  = pc_cur + c_step;
          end
          if (w_halt)      w_state_next = S_HALT;
          else if (stall)  w_state_next = S_WAIT_STALL;
          else             w_state_next = S_REQ;
        end else if (w_redirect) begin
          // Address must hold while waiting, so the redirect is deferred
          flush           = 1'b1;
          w_pend_vld_next = 1'b1;
          w_pend_tgt_next = w_tgt;
        end
      end

      S_WAIT_STALL: begin
        busy = 1'b1;
        if (w_redirect) begin
          pc_write = 1'b1;
          pc_next  = w_tgt;
          flush    = 1'b1;
        end
        if (w_halt)      w_state_next = S_HALT;
        else if (!stall) w_state_next = S_REQ;
      end

      S_HALT: begin
        if (start && !halt_req) w_state_next = S_REQ;
      end

      default: w_state_next = S_IDLE;
    endcase

    if (reset) begin
      imem_req = 1'b0;
      pc_write = 1'b1;
      pc_next  = RESET_PC;
      if_valid = 1'b0;
      flush    = 1'b0;
      busy     = 1'b0;
    end
  end

endmodule
`default_nettype wire
